// File: rtl/rxpy_wordpack_if.sv
// rxpy_wordpack_if
//   Bundles the payload-bit input stream, the rx payload buffer write port
//   and the packer status signals of rxpy_wordpack.
//   master : the packer (consumes the bit stream, drives buffer write/status)
//   slave  : the surrounding link controller / buffer side
//
//   header_st_p      start-of-packet pulse, clears packing state
//   dec_py_period    payload decode window
//   dec_pybit        decoded payload bit
//   dec_pybit_valid  one-cycle strobe per payload bit
//   rxlnctrl_addr    buffer word address (8 bits)
//   rxlnctrl_din     buffer write data (32 bits)
//   rxlnctrl_we      buffer write strobe
//   rxpy_bitcount    payload bits accepted since last header (0..8192)
//   rxpy_done_p      payload fully committed pulse
//   rxpy_ovf         sticky overflow flag
`timescale 1ns/1ps
interface rxpy_wordpack_if;
  logic        header_st_p;
  logic        dec_py_period;
  logic        dec_pybit;
  logic        dec_pybit_valid;
  logic [7:0]  rxlnctrl_addr;
  logic [31:0] rxlnctrl_din;
  logic        rxlnctrl_we;
  logic [13:0] rxpy_bitcount;
  logic        rxpy_done_p;
  logic        rxpy_ovf;

  modport master (
    input  header_st_p, dec_py_period, dec_pybit, dec_pybit_valid,
    output rxlnctrl_addr, rxlnctrl_din, rxlnctrl_we,
    output rxpy_bitcount, rxpy_done_p, rxpy_ovf
  );

  modport slave (
    output header_st_p, dec_py_period, dec_pybit, dec_pybit_valid,
    input  rxlnctrl_addr, rxlnctrl_din, rxlnctrl_we,
    input  rxpy_bitcount, rxpy_done_p, rxpy_ovf
  );
endinterface

// File: rtl/rxpy_wordpack.sv
// rxpy_wordpack
//   Receive payload packer. Collects decoded payload bits LSB-first into
//   32-bit words and writes each completed word, plus a trailing partial
//   word at end of payload, into the rx payload buffer (256 x 32 bits).
//   Payload bit n lands in word n[12:5], bit n[4:0].
//
//   clk_6M  system clock
//   rstz    asynchronous active-low reset
//   bus     rxpy_wordpack_if.master: bit stream in, buffer write port and
//           status (bitcount, done pulse, sticky overflow) out
`timescale 1ns/1ps
module rxpy_wordpack (
  input  logic             clk_6M,
  input  logic             rstz,
  rxpy_wordpack_if.master  bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        period_p1;
  logic [31:0] wordreg;
  logic [31:0] word_nxt;
  logic [13:0] bitcount;
  logic        full;
  logic        ovf;
  logic [7:0]  wr_addr;
  logic [31:0] wr_din;
  logic        wr_en;
  logic        done_p;

  logic        fall;
  logic        take;
  logic        accept;
  logic        drop_ovf;
  logic        word_done;
  logic        flush_go;

  assign fall = !bus.dec_py_period && period_p1;

  // State register
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control decisions
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    accept    = 1'b0;
    drop_ovf  = 1'b0;
    word_done = 1'b0;
    flush_go  = 1'b0;
    word_nxt  = wordreg;
    word_nxt[bitcount[4:0]] = bus.dec_pybit;

    case (state)
      IDLE:    if (bus.dec_py_period) state_nxt = COLLECT;
      COLLECT: if (fall) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // IDLE also accepts so the first bit of a window is not lost while the
    // FSM is still entering COLLECT; bits during FLUSH are dropped.
    take = bus.dec_py_period && bus.dec_pybit_valid &&
           (state == COLLECT || state == IDLE);
    if (take) begin
      if (full) drop_ovf = 1'b1;
      else      accept   = 1'b1;
    end
    word_done = accept && (bitcount[4:0] == 5'd31);
    // Flush outputs are registered here so they appear in the FLUSH cycle.
    flush_go  = (state == COLLECT) && fall;

    if (bus.header_st_p) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      drop_ovf  = 1'b0;
      word_done = 1'b0;
      flush_go  = 1'b0;
    end
  end

  // Packing datapath and registered write port
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      period_p1 <= 1'b0;
      wordreg   <= '0;
      bitcount  <= '0;
      full      <= 1'b0;
      ovf       <= 1'b0;
      wr_addr   <= '0;
      wr_din    <= '0;
      wr_en     <= 1'b0;
      done_p    <= 1'b0;
    end else begin
      period_p1 <= bus.dec_py_period;
      wr_en     <= 1'b0;
      done_p    <= 1'b0;
      if (bus.header_st_p) begin
        wordreg  <= '0;
        bitcount <= '0;
        full     <= 1'b0;
        ovf      <= 1'b0;
      end else begin
        if (accept) begin
          bitcount <= bitcount + 14'd1;
          if (word_done) begin
            wordreg <= '0;
            wr_en   <= 1'b1;
            wr_addr <= bitcount[12:5];
            wr_din  <= word_nxt;
            if (bitcount[12:5] == 8'd255) full <= 1'b1;
          end else begin
            wordreg <= word_nxt;
          end
        end
        if (drop_ovf) ovf <= 1'b1;
        // No bit is accepted while the window is low, so the flush write can
        // never coincide with a full-word write.
        if (flush_go) begin
          done_p <= 1'b1;
          if (bitcount[4:0] != 5'd0) begin
            wr_en   <= 1'b1;
            wr_addr <= bitcount[12:5];
            wr_din  <= wordreg;
          end
        end
      end
    end
  end

  assign bus.rxlnctrl_addr = wr_addr;
  assign bus.rxlnctrl_din  = wr_din;
  assign bus.rxlnctrl_we   = wr_en;
  assign bus.rxpy_bitcount = bitcount;
  assign bus.rxpy_done_p   = done_p;
  assign bus.rxpy_ovf      = ovf;

endmodule

// File: tb/tb_rxpy_wordpack.sv
`timescale 1ns/1ps
module tb_rxpy_wordpack;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;

  rxpy_wordpack_if bus();

  rxpy_wordpack dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus)
  );

  always #83 clk_6M = ~clk_6M;

  int cyc = 0;
  always @(posedge clk_6M) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  int          wr_n     = 0;
  int          done_n   = 0;
  int          done_cyc = 0;
  logic [7:0]  wr_addr [300];
  logic [31:0] wr_din  [300];
  int          wr_cyc  [300];

  // Write/done logger, sampled on the inactive edge
  always @(negedge clk_6M) begin
    if (bus.rxlnctrl_we === 1'b1) begin
      if (wr_n < 300) begin
        wr_addr[wr_n] = bus.rxlnctrl_addr;
        wr_din[wr_n]  = bus.rxlnctrl_din;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n++;
    end
    if (bus.rxpy_done_p === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic clear_log();
    wr_n   = 0;
    done_n = 0;
  endtask

  task automatic idle_inputs();
    bus.header_st_p     = 1'b0;
    bus.dec_py_period   = 1'b0;
    bus.dec_pybit       = 1'b0;
    bus.dec_pybit_valid = 1'b0;
  endtask

  task automatic start_packet();
    bus.header_st_p = 1'b1;
    step();
    bus.header_st_p = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    step(); step();
    n_checks++; if (bus.rxlnctrl_addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", bus.rxlnctrl_addr); else n_pass++;
    n_checks++; if (bus.rxlnctrl_din !== 32'd0) $display("FAIL reset_din: got %h want 0", bus.rxlnctrl_din); else n_pass++;
    n_checks++; if (bus.rxlnctrl_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.rxlnctrl_we); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd0) $display("FAIL reset_bitcount: got %0d want 0", bus.rxpy_bitcount); else n_pass++;
    n_checks++; if (bus.rxpy_done_p !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.rxpy_done_p); else n_pass++;
    n_checks++; if (bus.rxpy_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.rxpy_ovf); else n_pass++;
    rstz = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    int last_acc;
    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = (i % 2 == 0);
      step();
    end
    last_acc = cyc;
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (wr_n !== 1) $display("FAIL single_wr_count: got %0d want 1", wr_n); else n_pass++;
    n_checks++; if (wr_addr[0] !== 8'd0) $display("FAIL single_addr: got %0d want 0", wr_addr[0]); else n_pass++;
    n_checks++; if (wr_din[0] !== 32'h55555555) $display("FAIL single_din: got %h want 55555555", wr_din[0]); else n_pass++;
    n_checks++; if (wr_cyc[0] !== last_acc) $display("FAIL single_latency: got cycle %0d want %0d", wr_cyc[0], last_acc); else n_pass++;
    n_checks++; if (done_n !== 1) $display("FAIL single_done_count: got %0d want 1", done_n); else n_pass++;
    n_checks++; if (done_cyc !== last_acc + 1) $display("FAIL single_done_cycle: got %0d want %0d", done_cyc, last_acc + 1); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd32) $display("FAIL single_bitcount: got %0d want 32", bus.rxpy_bitcount); else n_pass++;
  endtask

  task automatic test_partial_flush();
    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = 1'b1;
      step();
    end
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (wr_n !== 2) $display("FAIL partial_wr_count: got %0d want 2", wr_n); else n_pass++;
    n_checks++; if (wr_addr[0] !== 8'd0 || wr_din[0] !== 32'hFFFFFFFF) $display("FAIL partial_word0: got %0d/%h want 0/ffffffff", wr_addr[0], wr_din[0]); else n_pass++;
    n_checks++; if (wr_addr[1] !== 8'd1) $display("FAIL partial_addr1: got %0d want 1", wr_addr[1]); else n_pass++;
    n_checks++; if (wr_din[1] !== 32'h000000FF) $display("FAIL partial_din1: got %h want 000000ff", wr_din[1]); else n_pass++;
    n_checks++; if (done_n !== 1) $display("FAIL partial_done_count: got %0d want 1", done_n); else n_pass++;
    n_checks++; if (wr_cyc[1] !== done_cyc) $display("FAIL partial_done_with_write: got write cycle %0d want %0d", wr_cyc[1], done_cyc); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd40) $display("FAIL partial_bitcount: got %0d want 40", bus.rxpy_bitcount); else n_pass++;
  endtask

  task automatic test_sparse_empty();
    logic [4:0] pat;
    pat = 5'b11011;
    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = pat[i];
      step();
      bus.dec_pybit_valid = 1'b0;
      bus.dec_pybit       = 1'b0;
      for (int g = 0; g < 3; g++) step();
    end
    bus.dec_py_period = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (wr_n !== 1) $display("FAIL sparse_wr_count: got %0d want 1", wr_n); else n_pass++;
    n_checks++; if (wr_addr[0] !== 8'd0 || wr_din[0] !== 32'h0000001B) $display("FAIL sparse_word: got %0d/%h want 0/0000001b", wr_addr[0], wr_din[0]); else n_pass++;
    n_checks++; if (done_n !== 1 || wr_cyc[0] !== done_cyc) $display("FAIL sparse_done: got count %0d cycle %0d want 1 at %0d", done_n, done_cyc, wr_cyc[0]); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd5) $display("FAIL sparse_bitcount: got %0d want 5", bus.rxpy_bitcount); else n_pass++;

    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    step();
    bus.dec_py_period = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (done_n !== 1) $display("FAIL empty_done_count: got %0d want 1", done_n); else n_pass++;
    n_checks++; if (wr_n !== 0) $display("FAIL empty_wr_count: got %0d want 0", wr_n); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd0) $display("FAIL empty_bitcount: got %0d want 0", bus.rxpy_bitcount); else n_pass++;
  endtask

  task automatic test_overflow();
    int bad_addr;
    int bad_din;
    int wr_final;
    logic [31:0] exp_w;
    bad_addr = 0;
    bad_din  = 0;
    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 8200; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = (i % 3 == 0);
      step();
      if (i == 8191) begin
        n_checks++; if (bus.rxpy_ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", bus.rxpy_ovf); else n_pass++;
      end
      if (i == 8192) begin
        n_checks++; if (bus.rxpy_ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.rxpy_ovf); else n_pass++;
      end
    end
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    for (int i = 0; i < 2; i++) step();
    wr_final = wr_n;
    for (int i = 0; i < 3; i++) step();
    for (int w = 0; w < 256; w++) begin
      for (int j = 0; j < 32; j++) exp_w[j] = ((32 * w + j) % 3 == 0);
      if (wr_addr[w] !== w[7:0]) bad_addr++;
      if (wr_din[w] !== exp_w) bad_din++;
    end
    n_checks++; if (wr_n !== 256) $display("FAIL ovf_wr_count: got %0d want 256", wr_n); else n_pass++;
    n_checks++; if (bad_addr !== 0) $display("FAIL ovf_addrs: got %0d bad addresses want 0", bad_addr); else n_pass++;
    n_checks++; if (bad_din !== 0) $display("FAIL ovf_data: got %0d bad words want 0", bad_din); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd8192) $display("FAIL ovf_bitcount: got %0d want 8192", bus.rxpy_bitcount); else n_pass++;
    n_checks++; if (done_n !== 1 || wr_final !== 256) $display("FAIL ovf_done: got done %0d writes %0d want 1/256", done_n, wr_final); else n_pass++;
    n_checks++; if (bus.rxpy_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.rxpy_ovf); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    clear_log();
    start_packet();
    n_checks++; if (bus.rxpy_ovf !== 1'b0 || bus.rxpy_bitcount !== 14'd0) $display("FAIL header_clear: got ovf %b count %0d want 0/0", bus.rxpy_ovf, bus.rxpy_bitcount); else n_pass++;
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = 1'b1;
      step();
    end
    n_checks++; if (bus.rxpy_bitcount !== 14'd20) $display("FAIL abort_pre_count: got %0d want 20", bus.rxpy_bitcount); else n_pass++;
    bus.header_st_p = 1'b1;
    step();
    bus.header_st_p     = 1'b0;
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (bus.rxpy_bitcount !== 14'd0) $display("FAIL abort_bitcount: got %0d want 0", bus.rxpy_bitcount); else n_pass++;
    n_checks++; if (wr_n !== 0) $display("FAIL abort_wr_count: got %0d want 0", wr_n); else n_pass++;
    n_checks++; if (done_n !== 0) $display("FAIL abort_done_count: got %0d want 0", done_n); else n_pass++;
    n_checks++; if (bus.rxpy_ovf !== 1'b0) $display("FAIL abort_ovf: got %b want 0", bus.rxpy_ovf); else n_pass++;

    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = pat[i];
      step();
    end
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++; if (wr_n !== 1 || wr_addr[0] !== 8'd0) $display("FAIL abort_next_addr: got %0d writes addr %0d want 1 at 0", wr_n, wr_addr[0]); else n_pass++;
    n_checks++; if (wr_din[0] !== 32'hDEADBEEF) $display("FAIL abort_next_din: got %h want deadbeef", wr_din[0]); else n_pass++;
  endtask

  task automatic test_reset_midword();
    clear_log();
    start_packet();
    bus.dec_py_period = 1'b1;
    for (int i = 0; i < 31; i++) begin
      bus.dec_pybit_valid = 1'b1;
      bus.dec_pybit       = 1'b1;
      step();
    end
    n_checks++; if (bus.rxpy_bitcount !== 14'd31) $display("FAIL rstmid_pre_count: got %0d want 31", bus.rxpy_bitcount); else n_pass++;
    #10;
    rstz = 1'b0;
    bus.dec_pybit_valid = 1'b0;
    bus.dec_py_period   = 1'b0;
    #1;
    n_checks++; if (bus.rxpy_bitcount !== 14'd0) $display("FAIL rstmid_async_count: got %0d want 0", bus.rxpy_bitcount); else n_pass++;
    n_checks++; if (bus.rxlnctrl_din !== 32'd0) $display("FAIL rstmid_async_din: got %h want 0", bus.rxlnctrl_din); else n_pass++;
    step(); step();
    rstz = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (wr_n !== 0) $display("FAIL rstmid_wr_count: got %0d want 0", wr_n); else n_pass++;
    n_checks++; if (done_n !== 0) $display("FAIL rstmid_done_count: got %0d want 0", done_n); else n_pass++;
    n_checks++; if (bus.rxlnctrl_addr !== 8'd0 || bus.rxlnctrl_we !== 1'b0) $display("FAIL rstmid_port: got addr %0d we %b want 0/0", bus.rxlnctrl_addr, bus.rxlnctrl_we); else n_pass++;
    n_checks++; if (bus.rxpy_bitcount !== 14'd0 || bus.rxpy_ovf !== 1'b0) $display("FAIL rstmid_status: got count %0d ovf %b want 0/0", bus.rxpy_bitcount, bus.rxpy_ovf); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_word();
    test_partial_flush();
    test_sparse_empty();
    test_overflow();
    test_abort();
    test_reset_midword();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rxpy_wordpack.md
# rxpy_wordpack

Receive-side payload packer for the baseband link controller. It takes the decoded payload bit stream, one bit per strobe, during the payload decode window. It assembles the bits LSB-first into 32-bit words and writes them through the link-controller write port of the rx ACL/SCO payload buffers. It is the rx counterpart of the tx path's word-to-bit serializer: payload bit n lands in word n[12:5], bit n[4:0], the same mapping the tx side uses to read.

## Interface
- No parameters. Buffer depth is fixed: 256 words × 32 bits = 8192 payload bits.
- clk_6M  in  1  system clock, 6 MHz
- rstz  in  1  asynchronous active-low reset
- header_st_p  in  1  start-of-packet pulse; clears all packing state
- dec_py_period  in  1  payload decode window; high while payload bits are arriving
- dec_pybit  in  1  decoded payload bit
- dec_pybit_valid  in  1  strobe, one cycle per bit; ignored while dec_py_period=0
- rxlnctrl_addr  out  8  buffer word address of the current write
- rxlnctrl_din  out  32  word being written
- rxlnctrl_we  out  1  write strobe, one cycle per word
- rxpy_bitcount  out  14  payload bits accepted since the last header_st_p (0..8192)
- rxpy_done_p  out  1  one-cycle pulse; payload fully committed to the buffer
- rxpy_ovf  out  1  sticky; a bit arrived after the buffer was full

## Operation
- State machine with three states:
  - IDLE: waiting for a payload window.
  - COLLECT: accepting bits.
  - FLUSH: single cycle that commits a partial word and/or issues done.
- Transitions:
  - IDLE → COLLECT when dec_py_period=1.
  - COLLECT → FLUSH on the falling edge of dec_py_period: the cycle where dec_py_period=0 and its registered copy is 1.
  - FLUSH → IDLE unconditionally.
- Bit acceptance requires all of: state COLLECT (or IDLE with dec_py_period=1), dec_py_period=1, dec_pybit_valid=1, and buffer not full. On acceptance:
  - wordreg[bitcount[4:0]] ← dec_pybit.
  - bitcount increments by 1.
- Word write: when an accepted bit has bitcount[4:0]=31, register a write for the next cycle with these values:
  - din = the completed word,
  - addr = bitcount[12:5] before the increment,
  - wordreg cleared to 0.
- Full: set when word 255 is written. While full, further valid bits are dropped and rxpy_ovf is set. bitcount saturates at 8192.
- FLUSH: if bitcount[4:0]≠0, the partial word is written in this cycle:
  - addr = bitcount[12:5],
  - unfilled high bits are 0,
  - rxpy_done_p=1 in the same cycle.
  If bitcount[4:0]=0 (this includes bitcount=0), there is no write and only rxpy_done_p=1.
- header_st_p has priority over everything. In the cycle it is high:
  - bitcount, wordreg, full and rxpy_ovf are cleared, and the state goes to IDLE;
  - any write or done scheduled for the next cycle is cancelled;
  - a bit strobed in the same cycle is dropped.
- rxlnctrl_addr and rxlnctrl_din hold their last written values when rxlnctrl_we=0.

## Timing
- Reset values of every output: rxlnctrl_addr=0, rxlnctrl_din=0, rxlnctrl_we=0, rxpy_bitcount=0, rxpy_done_p=0, rxpy_ovf=0.
- Full-word write latency: rxlnctrl_we is high exactly 1 cycle after the cycle that accepts the 32nd bit of the word. All outputs are registered.
- Back-to-back writes: bits may arrive on every cycle, so writes can occur every 32 cycles minimum. No write port stall exists.
- End of payload:
  - Fall detected at cycle T.
  - FLUSH occupies T+1; rxpy_done_p and any partial write occur at T+1.
  - A bit accepted at T-1 that completes a word writes at T. It never collides with the flush write.
- rxpy_bitcount updates in the cycle after acceptance and stays valid until the next header_st_p.
- A new dec_py_period rising during FLUSH is entered from IDLE in the following cycle. Bits in the FLUSH cycle are dropped.
- rstz asserted mid-operation: all state and outputs go to reset values immediately. No partial write is issued.

## Test plan
- **Single full word:** header_st_p, then 32 bits alternating 1,0 starting at bit 0 on consecutive cycles → one write, addr=0, din=32'h55555555, one cycle after the 32nd bit; rxpy_done_p one cycle after the window falls, with no further write; bitcount=32.
- **Partial flush:** 40 bits, all 1 → write addr=0 din=32'hFFFFFFFF, then in FLUSH write addr=1 din=32'h000000FF with rxpy_done_p in the same cycle; bitcount=40.
- **Sparse strobes and empty payload:** 5 bits 1,1,0,1,1 with valid gaps of 3 cycles → FLUSH write addr=0 din=32'h0000001B. A window with 0 bits → done pulse, no write.
- **Overflow:** 8200 bits → 256 writes (addrs 0..255); rxpy_ovf=1 after bit 8193; bitcount=8192; done with no extra write.
- **Abort and priority:** 20 bits, then header_st_p coincident with a valid strobe → no write, bitcount=0, ovf=0. The next payload of 32 bits writes addr=0.
- **Reset mid-word:** rstz low after 31 bits → outputs at reset values, no write in any later cycle.
